ps2_key_event_decoder: RTL
==========================

# ps2_key_event_decoder

Parametrised successor to the PS/2 display top: turns the raw scan-code byte stream from `ps2_keyboard` into typed key events (make/break, extended) and buffers them in a FIFO. It tracks the currently held key and counts key presses, with optional typematic-repeat filtering. It sits between `ps2_keyboard` and consumers such as the seven-segment display logic, the ASCII ROM or a CPU-side register port.

## Interface

Parameters:

- `CNT_W`, default 8: width of the press counter.
- `FIFO_DEPTH`, default 4: event FIFO depth; must be a power of 2 and at least 2.
- `FILTER_REPEAT`, default 1: when 1, typematic repeats of the held key produce no event and no count.

Ports. One clock `clk`; reset `clrn` is asynchronous and active-low.

- `clk` in 1: system clock; all state updates on the rising edge.
- `clrn` in 1: asynchronous active-low reset.
- `rx_data` in 8: byte from the receiver FIFO head.
- `rx_ready` in 1: receiver holds at least one byte.
- `rx_overflow` in 1: receiver dropped a byte.
- `nextdata_n` out 1: one-cycle low pulse that pops the receiver.
- `evt_valid` out 1: the event FIFO is non-empty.
- `evt_ready` in 1: the consumer accepts the head event.
- `evt_code` out 8: scan code of the head event.
- `evt_ext` out 1: the head event carried an E0 prefix.
- `evt_break` out 1: the head event is a release (F0 prefix).
- `key_held` out 1: a key is currently considered pressed.
- `held_code` out 8: code of the held key.
- `held_ext` out 1: extended flag of the held key.
- `press_count` out CNT_W: accepted make events, wrapping modulo 2^CNT_W.
- `err_sticky` out 1: set on `rx_overflow` or on an event FIFO drop; cleared only by reset.

## Operation

Byte-fetch FSM:

- `S_WAIT`: if `rx_ready`=1, capture `rx_data`, decode it, drive `nextdata_n`=0, and go to `S_POP`.
- `S_POP`: `nextdata_n`=1; go to `S_SETTLE`.
- `S_SETTLE`: wait one cycle so `rx_ready` reflects the pop; go to `S_WAIT`.

Peak throughput is therefore one byte per 3 cycles. No byte is consumed twice.

Decode of the captured byte `b`:

- `b`=E0: set `ext_pend`. No event.
- `b`=F0: set `brk_pend`. No event.
- Any other value: form the event {`brk_pend`, `ext_pend`, `b`}, then clear both pending flags.

Make event (`brk_pend`=0):

- Repeat case: if `FILTER_REPEAT`=1, `key_held`=1 and {`held_ext`,`held_code`} equals {ext,`b`}, discard the event. No push, no count.
- Otherwise: push the event, `press_count` +1 (wraps), `key_held`=1, `held_code`=`b`, `held_ext`=ext.

Break event (`brk_pend`=1):

- Always push the event.
- If it matches the held key, clear `key_held`. `held_code` and `held_ext` keep their last values.
- A break never counts.

Event FIFO:

- First-word-fall-through: the head event is presented on `evt_code`/`evt_ext`/`evt_break` whenever `evt_valid`=1.
- Pop when `evt_valid` && `evt_ready`.
- Push while full with no pop in the same cycle: the event is dropped and `err_sticky` is set. `press_count` and held-key tracking still update.
- Push and pop in the same cycle while full: both occur, nothing is dropped, and occupancy stays at full.
- Push and pop in the same cycle while empty: the pop is ignored (`evt_valid`=0) and the push lands.
- Output values are undefined while `evt_valid`=0; the bench must not check them.

`rx_overflow` sampled high on any edge sets `err_sticky`.

## Timing

- Reset (async assert, sync-safe release): FSM in `S_WAIT`; `nextdata_n`=1; `ext_pend`=`brk_pend`=0; FIFO empty, so `evt_valid`=0; `key_held`=0; `held_code`=0; `held_ext`=0; `press_count`=0; `err_sticky`=0.
- `rx_ready` is sampled high at edge N. At edge N the byte is decoded, the event is written, and held/count state updates. After edge N, `evt_valid`=1 (if the FIFO was empty) and `nextdata_n`=0 for exactly one cycle.
- End-to-end latency is 1 cycle from byte sampled to event visible.
- A prefix byte followed by its code byte appears as an event after the second byte's capture edge.
- Reset mid-sequence discards pending prefixes and all queued events.

## Test plan

- Bytes 1C, F0, 1C with `evt_ready`=1 → events {break=0,ext=0,1C}, then {1,0,1C}; `press_count`=1; `key_held` goes 1 then 0.
- Bytes E0 75, E0 F0 75 → events {0,1,75}, then {1,1,75}; `held_ext`=1 while held.
- Bytes 1C 1C 1C F0 1C:
  - `FILTER_REPEAT`=1 → one make and one break, count 1.
  - `FILTER_REPEAT`=0 → three makes and one break, count 3.
- `evt_ready`=0, `FIFO_DEPTH`=4, makes 15 16 1E 26 2E → four events queued and `err_sticky`=1, count 5. Then `evt_ready`=1 → drains 15, 16, 1E, 26 in order.
- `CNT_W`=4: 17 make/break pairs of code 1C → `press_count`=1.
- Send E0 F0, pulse `clrn` low, release, send 1C → single event {0,0,1C}; `nextdata_n` reads 1 during reset.

Source files
------------

// File: rtl/ps2_key_event_decoder_if.sv
// Bundle between the PS/2 receiver FIFO, the key-event decoder and its consumer.
// The slave modport is the decoder's view; the master modport is the surrounding
// logic that feeds receiver bytes in and drains events out.
interface ps2_key_event_decoder_if #(
  parameter int CNT_W = 8
);
  // receiver side
  logic [7:0]       rx_data;
  logic             rx_ready;
  logic             rx_overflow;
  logic             nextdata_n;
  // event stream
  logic             evt_valid;
  logic             evt_ready;
  logic [7:0]       evt_code;
  logic             evt_ext;
  logic             evt_break;
  // held-key status
  logic             key_held;
  logic [7:0]       held_code;
  logic             held_ext;
  logic [CNT_W-1:0] press_count;
  logic             err_sticky;

  modport slave (
    input  rx_data, rx_ready, rx_overflow, evt_ready,
    output nextdata_n, evt_valid, evt_code, evt_ext, evt_break,
    output key_held, held_code, held_ext, press_count, err_sticky
  );

  modport master (
    output rx_data, rx_ready, rx_overflow, evt_ready,
    input  nextdata_n, evt_valid, evt_code, evt_ext, evt_break,
    input  key_held, held_code, held_ext, press_count, err_sticky
  );
endinterface

// File: rtl/ps2_key_event_decoder.sv
// PS/2 key-event decoder: fetches scan-code bytes from the receiver FIFO,
// folds E0/F0 prefixes into typed make/break events, tracks the held key,
// counts accepted presses and queues events in a first-word-fall-through FIFO.
// FIFO_DEPTH must be a power of two and at least 2 so the pointers wrap freely.
module ps2_key_event_decoder #(
  parameter int CNT_W         = 8,
  parameter int FIFO_DEPTH    = 4,
  parameter int FILTER_REPEAT = 1
) (
  input  logic                  clk,
  input  logic                  clrn,
  ps2_key_event_decoder_if.slave bus
);

  localparam int            AW       = $clog2(FIFO_DEPTH);
  localparam int            EW       = 10;                // {break, ext, code}
  localparam logic [7:0]    CODE_EXT = 8'hE0;
  localparam logic [7:0]    CODE_BRK = 8'hF0;
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_WAIT   = 2'd0,
    S_POP    = 2'd1,
    S_SETTLE = 2'd2
  } state_t;

  // byte-fetch FSM
  state_t           r_state;
  state_t           w_state_next;
  logic             w_capture;
  logic             r_nextdata_n;

  // prefix tracking and key state
  logic             r_ext_pend;
  logic             r_brk_pend;
  logic             r_key_held;
  logic [7:0]       r_held_code;
  logic             r_held_ext;
  logic [CNT_W-1:0] r_press_count;
  logic             r_err_sticky;

  // decode of the captured byte
  logic [7:0]       w_byte;
  logic             w_is_ext;
  logic             w_is_brk;
  logic             w_is_code;
  logic             w_key_match;
  logic             w_is_repeat;
  logic             w_accept_make;
  logic             w_release;
  logic             w_push;
  logic [EW-1:0]    w_evt;

  // event FIFO
  logic [EW-1:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_wr;
  logic             w_drop;

  // Fetch sequencing: capture in S_WAIT, then two idle cycles so the receiver's
  // rx_ready has caught up with the pop before the next byte is looked at.
  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    case (r_state)
      S_WAIT: begin
        if (bus.rx_ready) begin
          w_capture    = 1'b1;
          w_state_next = S_POP;
        end
      end
      S_POP:    w_state_next = S_SETTLE;
      S_SETTLE: w_state_next = S_WAIT;
      default:  w_state_next = S_WAIT;
    endcase
  end

  // State register; nextdata_n is registered so the pop pulse is glitch-free
  // and lines up with the cycle spent in S_POP.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state      <= S_WAIT;
      r_nextdata_n <= 1'b1;
    end else begin
      r_state      <= w_state_next;
      r_nextdata_n <= ~w_capture;
    end
  end

  // Classify the captured byte and decide what the event does to the key state.
  // A repeat is only a make of exactly the key already held (same E0 flag).
  always_comb begin
    w_byte        = bus.rx_data;
    w_is_ext      = w_capture && (w_byte == CODE_EXT);
    w_is_brk      = w_capture && (w_byte == CODE_BRK);
    w_is_code     = w_capture && (w_byte != CODE_EXT) && (w_byte != CODE_BRK);
    w_key_match   = r_key_held && (r_held_ext == r_ext_pend) && (r_held_code == w_byte);
    w_is_repeat   = (FILTER_REPEAT != 0) && !r_brk_pend && w_key_match;
    w_accept_make = w_is_code && !r_brk_pend && !w_is_repeat;
    w_release     = w_is_code && r_brk_pend && w_key_match;
    w_push        = w_is_code && (r_brk_pend || !w_is_repeat);
    w_evt         = {r_brk_pend, r_ext_pend, w_byte};
  end

  // Prefix flags accumulate until a code byte consumes them.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_ext_pend <= 1'b0;
      r_brk_pend <= 1'b0;
    end else if (w_is_ext) begin
      r_ext_pend <= 1'b1;
    end else if (w_is_brk) begin
      r_brk_pend <= 1'b1;
    end else if (w_is_code) begin
      r_ext_pend <= 1'b0;
      r_brk_pend <= 1'b0;
    end
  end

  // Held-key tracking and press counting; these update even if the FIFO drops
  // the event, so the status view stays truthful when the consumer stalls.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_key_held    <= 1'b0;
      r_held_code   <= 8'h00;
      r_held_ext    <= 1'b0;
      r_press_count <= '0;
    end else if (w_accept_make) begin
      r_key_held    <= 1'b1;
      r_held_code   <= w_byte;
      r_held_ext    <= r_ext_pend;
      r_press_count <= r_press_count + CNT_W'(1);
    end else if (w_release) begin
      r_key_held    <= 1'b0;
    end
  end

  // FIFO control: a pop frees the slot in the same cycle, so push+pop while
  // full is accepted; a pop while empty cannot happen because evt_valid is low.
  always_comb begin
    w_empty = (r_count == '0);
    w_full  = (r_count == FULL_CNT);
    w_pop   = !w_empty && bus.evt_ready;
    w_wr    = w_push && (!w_full || w_pop);
    w_drop  = w_push && w_full && !w_pop;
  end

  // Event storage; contents need no reset because occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= w_evt;
    end
  end

  // Read/write pointers and occupancy.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky error: receiver overflow or an event lost to a full FIFO.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_err_sticky <= 1'b0;
    end else if (bus.rx_overflow || w_drop) begin
      r_err_sticky <= 1'b1;
    end
  end

  assign bus.nextdata_n  = r_nextdata_n;
  assign bus.evt_valid   = !w_empty;
  assign bus.evt_break   = r_mem[r_rd_ptr][9];
  assign bus.evt_ext     = r_mem[r_rd_ptr][8];
  assign bus.evt_code    = r_mem[r_rd_ptr][7:0];
  assign bus.key_held    = r_key_held;
  assign bus.held_code   = r_held_code;
  assign bus.held_ext    = r_held_ext;
  assign bus.press_count = r_press_count;
  assign bus.err_sticky  = r_err_sticky;

endmodule
